// File: rtl/mux_8_1_pkg.sv
// Shared constants and state encoding for the 8:1 mux round-robin arbiter.
package mux_8_1_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick_8.sv
// Combinational wrap-around search: first set request bit at or above i_ptr,
// wrapping 7->0.
module rr_pick_8
  import mux_8_1_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_any
);

  logic [SEL_W-1:0] w_cand;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    o_idx  = i_ptr;
    o_any  = 1'b0;
    w_cand = '0;
    // Walk from the farthest offset down so the nearest set bit wins last.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_cand = i_ptr + SEL_W'(i);
      if (i_req[w_cand]) begin
        o_idx = w_cand;
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_8_1_rr_arb.sv
// Round-robin arbiter driving a shared 8:1 mux: registered enable, select code
// and one-hot grant, with a per-grant hold limit of HOLD_MAX cycles.
module mux_8_1_rr_arb
  import mux_8_1_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_REQ-1:0] i_req,
  output logic             o_en,
  output logic [SEL_W-1:0] o_sel_code,
  output logic [N_REQ-1:0] o_grant
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  state_t           r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [3:0]       r_hold_cnt;
  logic [SEL_W-1:0] r_sel_code;
  logic             r_en;
  logic [N_REQ-1:0] r_grant;

  logic             w_release;
  logic [SEL_W-1:0] w_search_ptr;
  logic [SEL_W-1:0] w_idx;
  logic             w_any;

  // During a grant the search must already start from the post-release ptr so
  // the next winner is loaded at the same edge the current grant ends.
  assign w_release    = (r_state == GRANT) &&
                        (!i_req[r_sel_code] || (r_hold_cnt == HOLD_LAST));
  assign w_search_ptr = (r_state == GRANT) ? (r_sel_code + 3'd1) : r_ptr;

  rr_pick_8 u_pick (
    .i_req (i_req),
    .i_ptr (w_search_ptr),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_sel_code <= '0;
      r_en       <= 1'b0;
      r_grant    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state    <= GRANT;
            r_en       <= 1'b1;
            r_sel_code <= w_idx;
            r_grant    <= N_REQ'(1) << w_idx;
            r_hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_ptr      <= r_sel_code + 3'd1;
            r_hold_cnt <= '0;
            if (w_any) begin
              r_sel_code <= w_idx;
              r_grant    <= N_REQ'(1) << w_idx;
            end else begin
              r_state <= IDLE;
              r_en    <= 1'b0;
              r_grant <= '0;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_en       = r_en;
  assign o_sel_code = r_sel_code;
  assign o_grant    = r_grant;

endmodule

// File: tb/tb_mux_8_1_rr_arb.sv
// Directed-vector bench for mux_8_1_rr_arb with HOLD_MAX=4; inputs change 1ns
// after each rising edge and outputs are sampled at that same point.
module tb_mux_8_1_rr_arb;

  logic       i_clk;
  logic       i_rst_n;
  logic [7:0] i_req;
  logic       o_en;
  logic [2:0] o_sel_code;
  logic [7:0] o_grant;

  int n_checks = 0;
  int n_fail   = 0;

  mux_8_1_rr_arb #(.HOLD_MAX(4)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req      (i_req),
    .o_en       (o_en),
    .o_sel_code (o_sel_code),
    .o_grant    (o_grant)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_req   = 8'h00;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_req   = 8'h00;
    #2;
    n_checks++;
    if (o_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_en: got %b want 0", o_en);
    end
    n_checks++;
    if (o_grant !== 8'h00) begin
      n_fail++; $display("FAIL reset_grant: got %h want 00", o_grant);
    end
    n_checks++;
    if (o_sel_code !== 3'd0) begin
      n_fail++; $display("FAIL reset_sel: got %0d want 0", o_sel_code);
    end
    do_reset();
  endtask

  task automatic test_idle();
    i_req = 8'h00;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (o_en !== 1'b0 || o_grant !== 8'h00 || o_sel_code !== 3'd0) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: got en=%b grant=%h sel=%0d want en=0 grant=00 sel=0",
                 k, o_en, o_grant, o_sel_code);
      end
    end
  endtask

  task automatic test_single_hold();
    do_reset();
    i_req = 8'h10;
    // Eight cycles span the first 4-cycle grant and the gapless re-grant.
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if (o_en !== 1'b1 || o_sel_code !== 3'd4 || o_grant !== 8'h10) begin
        n_fail++;
        $display("FAIL single_hold_cycle%0d: got en=%b sel=%0d grant=%h want en=1 sel=4 grant=10",
                 k, o_en, o_sel_code, o_grant);
      end
    end
    i_req = 8'h00;
    step();
    n_checks++;
    if (o_en !== 1'b0 || o_grant !== 8'h00 || o_sel_code !== 3'd4) begin
      n_fail++;
      $display("FAIL single_release: got en=%b grant=%h sel=%0d want en=0 grant=00 sel=4",
               o_en, o_grant, o_sel_code);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_sel;
    logic [7:0] exp_grant;
    do_reset();
    i_req = 8'hFF;
    for (int k = 0; k < 36; k++) begin
      step();
      exp_sel   = 3'((k / 4) % 8);
      exp_grant = 8'h01 << exp_sel;
      n_checks++;
      if (o_en !== 1'b1 || o_sel_code !== exp_sel || o_grant !== exp_grant) begin
        n_fail++;
        $display("FAIL rr_cycle%0d: got en=%b sel=%0d grant=%h want en=1 sel=%0d grant=%h",
                 k, o_en, o_sel_code, o_grant, exp_sel, exp_grant);
      end
    end
    i_req = 8'h00;
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    i_req = 8'h80;
    step();
    n_checks++;
    if (o_sel_code !== 3'd7 || o_en !== 1'b1) begin
      n_fail++; $display("FAIL wrap_grant7: got sel=%0d en=%b want sel=7 en=1", o_sel_code, o_en);
    end
    i_req = 8'h81;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (o_sel_code !== 3'd7) begin
        n_fail++; $display("FAIL wrap_hold%0d: got sel=%0d want 7", k, o_sel_code);
      end
    end
    step();
    n_checks++;
    if (o_sel_code !== 3'd0 || o_en !== 1'b1 || o_grant !== 8'h01) begin
      n_fail++;
      $display("FAIL wrap_7to0: got sel=%0d en=%b grant=%h want sel=0 en=1 grant=01",
               o_sel_code, o_en, o_grant);
    end
    i_req = 8'h00;
    step();
  endtask

  task automatic test_drop_regrant();
    do_reset();
    i_req = 8'h04;
    step();
    n_checks++;
    if (o_sel_code !== 3'd2 || o_en !== 1'b1) begin
      n_fail++; $display("FAIL drop_grant2: got sel=%0d en=%b want sel=2 en=1", o_sel_code, o_en);
    end
    i_req = 8'h00;
    step();
    n_checks++;
    if (o_en !== 1'b0 || o_grant !== 8'h00) begin
      n_fail++; $display("FAIL drop_release: got en=%b grant=%h want en=0 grant=00", o_en, o_grant);
    end
    step();
    i_req = 8'h04;
    step();
    n_checks++;
    if (o_en !== 1'b1 || o_sel_code !== 3'd2 || o_grant !== 8'h04) begin
      n_fail++;
      $display("FAIL drop_regrant: got en=%b sel=%0d grant=%h want en=1 sel=2 grant=04",
               o_en, o_sel_code, o_grant);
    end
    i_req = 8'h00;
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    i_req = 8'h06;
    step();
    n_checks++;
    if (o_sel_code !== 3'd1) begin
      n_fail++; $display("FAIL b2b_first: got sel=%0d want 1", o_sel_code);
    end
    i_req = 8'h04;
    step();
    n_checks++;
    if (o_en !== 1'b1 || o_sel_code !== 3'd2 || o_grant !== 8'h04) begin
      n_fail++;
      $display("FAIL b2b_handoff: got en=%b sel=%0d grant=%h want en=1 sel=2 grant=04",
               o_en, o_sel_code, o_grant);
    end
    i_req = 8'h00;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    i_req = 8'h20;
    step();
    n_checks++;
    if (o_sel_code !== 3'd5 || o_en !== 1'b1) begin
      n_fail++; $display("FAIL arst_grant5: got sel=%0d en=%b want sel=5 en=1", o_sel_code, o_en);
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_en !== 1'b0 || o_grant !== 8'h00 || o_sel_code !== 3'd0) begin
      n_fail++;
      $display("FAIL arst_immediate: got en=%b grant=%h sel=%0d want en=0 grant=00 sel=0",
               o_en, o_grant, o_sel_code);
    end
    #1;
    i_rst_n = 1'b1;
    i_req   = 8'h21;
    step();
    n_checks++;
    if (o_en !== 1'b1 || o_sel_code !== 3'd0 || o_grant !== 8'h01) begin
      n_fail++;
      $display("FAIL arst_after: got en=%b sel=%0d grant=%h want en=1 sel=0 grant=01",
               o_en, o_sel_code, o_grant);
    end
    i_req = 8'h00;
    step();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_hold();
    test_round_robin();
    test_wrap();
    test_drop_regrant();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
